quadrature_generator: RTL and testbench
=======================================

Name: quadrature_generator

Overview:
- Transmit-side counterpart of the rotary encoder front end: converts single-cycle step requests into quadrature A/B waveforms and a push-button level, matching a mechanical detent encoder.
- Drives the encoder input pins of the Pong board from the paddle-AI / demo logic and serves as a stimulus source for decoder benches.
- Queues pending steps in a signed saturating counter and emits them one detent at a time with a mandatory idle gap, so downstream debounce/dead-zone logic sees clean, separated detents.

Parameters:
- PHASE_CYCLES, 1000, clocks each intermediate quadrature phase is held (>=1).
- GAP_CYCLES, 4000, clocks both lines stay high after a detent before the next may start (>=1).
- PRESS_CYCLES, 50000, clocks switch_n is held low per press request (>=1).
- MAX_PENDING, 7, saturation magnitude of the pending-step counter (1..127).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- step_up  input  1  request one clockwise detent (single-cycle pulse)
- step_down  input  1  request one counter-clockwise detent (single-cycle pulse)
- press  input  1  request one button press (single-cycle pulse)
- out_a  output  1  quadrature channel A (idle high)
- out_b  output  1  quadrature channel B (idle high)
- switch_n  output  1  push-button, active low (idle high)
- busy  output  1  high while a detent or gap is in progress
- pending  output  8  signed two's-complement count of queued steps (+ = up)
- dropped  output  1  one-cycle pulse when a request is lost to saturation

Behaviour:
- Reset (async assert, sync to clk on release): out_a=1, out_b=1, switch_n=1, busy=0, pending=0, dropped=0, FSM=IDLE, all timers 0.
- Request accounting per cycle: delta = step_up - step_down - (1 if detent starting this cycle with dir up) + (1 if starting with dir down). step_up and step_down together cancel (delta contribution 0, no drop).
- Saturation: if pending + request delta would exceed +MAX_PENDING or fall below -MAX_PENDING, request contribution discarded, pending unchanged by it, dropped=1 for that cycle; consumption still applied.
- FSM states: IDLE, P1, P2, P3, GAP.
- IDLE: A=1,B=1. If pending!=0 (registered value), latch dir = sign(pending), consume one step, go P1 next cycle; busy=1 from P1 onward.
- Up detent (B leads): P1 A=1,B=0; P2 A=0,B=0; P3 A=0,B=1; each held exactly PHASE_CYCLES clocks.
- Down detent (A leads): P1 A=0,B=1; P2 A=0,B=0; P3 A=1,B=0.
- After P3: GAP, A=1,B=1 for GAP_CYCLES clocks, then IDLE (busy=0 in IDLE). Back-to-back detents therefore separated by GAP_CYCLES+1 clocks of 11.
- Exactly one of A/B changes per phase transition; never both in one cycle.
- Latched dir is fixed for the whole detent; requests arriving mid-detent only modify pending. A down request during an up detent may drive pending negative; next detent then goes down.
- Latency: step pulse in cycle N with FSM idle and pending=0 -> pending=±1 at N+1, first A/B edge at N+2.
- Button: independent of FSM. press while switch_n=1 -> switch_n=0 next cycle for PRESS_CYCLES clocks then 1; press while already low ignored (not extended, no drop).
- Outputs are registered; no combinational path input->output.
- Timer widths from $clog2 of the largest of the three cycle parameters.

Decomposition:
- Shared package: FSM state encoding (IDLE,P1,P2,P3,GAP), direction constants, default timing constants for the board clock.
- One natural sub-module: quadrature_phase_timer (loadable down-counter with done flag), instanced for phase/gap timing and for the press timer.

Test Plan (PHASE_CYCLES=4, GAP_CYCLES=8, PRESS_CYCLES=6, MAX_PENDING=3):
- Single step_up at cycle 10 -> pending=1 at 11, 0 at 12; A/B = 10 (c12-15), 00 (16-19), 01 (20-23), 11 gap (24-31); busy low at 32.
- Single step_down -> A/B sequence 01,00,10,11 with same timing; pending returns to 0.
- Five step_up pulses in consecutive cycles while idle -> pending peaks at 3, dropped pulses on excess request(s), exactly the queued count of up detents emitted with 9-cycle 11 gaps.
- step_up and step_down same cycle -> pending stays 0, no detent, dropped=0.
- step_up then step_down during P2 of that detent -> current detent completes as up, pending=-1, next detent is down.
- press, then press again 2 cycles later; assert rst mid-detent -> switch_n low exactly 6 cycles; on rst A=B=1, switch_n=1, pending=0 immediately (async).

Source files
------------

// File: rtl/quadrature_generator_pkg.sv
// Shared types and constants for the quadrature step generator.
// Phase-to-pin mapping lives here so every user agrees on the A/B order.
package quadrature_generator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_P1,
    ST_P2,
    ST_P3,
    ST_GAP
  } state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int DEF_PHASE_CYCLES = 1000;
  localparam int DEF_GAP_CYCLES   = 4000;
  localparam int DEF_PRESS_CYCLES = 50000;
  localparam int DEF_MAX_PENDING  = 7;

  // Returns {A,B}; an up detent has B leading, a down detent has A leading.
  function automatic logic [1:0] phase_ab(state_e st, logic dir);
    case (st)
      ST_P1:   return (dir == DIR_UP) ? 2'b10 : 2'b01;
      ST_P2:   return 2'b00;
      ST_P3:   return (dir == DIR_UP) ? 2'b01 : 2'b10;
      default: return 2'b11;
    endcase
  endfunction

endpackage

// File: rtl/quadrature_phase_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module quadrature_phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/quadrature_generator.sv
// Turns step/press pulses into detent-shaped quadrature A/B and a button level.
// Steps queue in a saturating signed counter and drain one detent at a time.
module quadrature_generator
  import quadrature_generator_pkg::*;
#(
  parameter int PHASE_CYCLES = DEF_PHASE_CYCLES,
  parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
  parameter int PRESS_CYCLES = DEF_PRESS_CYCLES,
  parameter int MAX_PENDING  = DEF_MAX_PENDING
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step_up,
  input  logic       step_down,
  input  logic       press,
  output logic       out_a,
  output logic       out_b,
  output logic       switch_n,
  output logic       busy,
  output logic [7:0] pending,
  output logic       dropped
);

  localparam int MAX_PG  = (PHASE_CYCLES > GAP_CYCLES) ? PHASE_CYCLES : GAP_CYCLES;
  localparam int MAX_CYC = (MAX_PG > PRESS_CYCLES) ? MAX_PG : PRESS_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);

  localparam logic [TW-1:0] PH_LOAD  = TW'(PHASE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] PR_LOAD  = TW'(PRESS_CYCLES - 1);
  localparam logic signed [8:0] MAX_P = $signed(9'(MAX_PENDING));

  state_e             state_q, state_d;
  logic               dir_q, dir_d;
  logic [1:0]         ab_q, ab_d;
  logic               busy_q, busy_d;
  logic signed [7:0]  pend_q, pend_d;
  logic               drop_q, drop_d;
  logic               sw_q, sw_d;

  logic               tmr_load, tmr_done;
  logic [TW-1:0]      tmr_val;
  logic               prs_load, prs_done;
  logic signed [8:0]  cons, base, req, sum;

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    tmr_load = 1'b0;
    tmr_val  = PH_LOAD;
    cons     = 9'sd0;
    case (state_q)
      ST_IDLE: begin
        if (pend_q != 8'sd0) begin
          dir_d    = pend_q[7] ? DIR_DOWN : DIR_UP;
          cons     = pend_q[7] ? -9'sd1 : 9'sd1;
          state_d  = ST_P1;
          tmr_load = 1'b1;
        end
      end
      ST_P1: if (tmr_done) begin
        state_d  = ST_P2;
        tmr_load = 1'b1;
      end
      ST_P2: if (tmr_done) begin
        state_d  = ST_P3;
        tmr_load = 1'b1;
      end
      ST_P3: if (tmr_done) begin
        state_d  = ST_GAP;
        tmr_load = 1'b1;
        tmr_val  = GAP_LOAD;
      end
      ST_GAP: if (tmr_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    ab_d   = phase_ab(state_d, dir_d);
    busy_d = (state_d != ST_IDLE);

    // Consumption is always honoured; only the new request can be discarded.
    base = $signed({pend_q[7], pend_q}) - cons;
    req  = (step_up && !step_down) ? 9'sd1 :
           (step_down && !step_up) ? -9'sd1 : 9'sd0;
    sum  = base + req;
    if ((sum > MAX_P) || (sum < -MAX_P)) begin
      pend_d = base[7:0];
      drop_d = 1'b1;
    end else begin
      pend_d = sum[7:0];
      drop_d = 1'b0;
    end

    sw_d     = sw_q;
    prs_load = 1'b0;
    if (sw_q && press) begin
      sw_d     = 1'b0;
      prs_load = 1'b1;
    end else if (!sw_q && prs_done) begin
      sw_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_UP;
      ab_q    <= 2'b11;
      busy_q  <= 1'b0;
      pend_q  <= 8'sd0;
      drop_q  <= 1'b0;
      sw_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      ab_q    <= ab_d;
      busy_q  <= busy_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
      sw_q    <= sw_d;
    end
  end

  quadrature_phase_timer #(.W(TW)) u_det_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  quadrature_phase_timer #(.W(TW)) u_prs_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (prs_load),
    .load_val (PR_LOAD),
    .done     (prs_done)
  );

  assign out_a    = ab_q[1];
  assign out_b    = ab_q[0];
  assign switch_n = sw_q;
  assign busy     = busy_q;
  assign pending  = pend_q;
  assign dropped  = drop_q;

endmodule

// File: tb/tb_quadrature_generator.sv
// Bench for quadrature_generator: timeline-based reference model plus directed literal checks.
module tb_quadrature_generator;

  localparam int P   = 4;
  localparam int G   = 8;
  localparam int PR  = 6;
  localparam int M   = 3;
  localparam int DET = 3 * P + G;

  logic       clk = 1'b0;
  logic       rst;
  logic       step_up, step_down, press;
  logic       out_a, out_b, switch_n, busy, dropped;
  logic [7:0] pending;

  quadrature_generator #(
    .PHASE_CYCLES (P),
    .GAP_CYCLES   (G),
    .PRESS_CYCLES (PR),
    .MAX_PENDING  (M)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .step_up   (step_up),
    .step_down (step_down),
    .press     (press),
    .out_a     (out_a),
    .out_b     (out_b),
    .switch_n  (switch_n),
    .busy      (busy),
    .pending   (pending),
    .dropped   (dropped)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;

  // Model: a detent is a fixed timeline starting at m_start; a press is a window at p_start.
  int cyc;
  int m_pending;
  int m_start;
  bit m_up;
  int p_start;
  bit m_drop;

  task automatic model_reset();
    m_pending = 0;
    m_start   = -100000;
    p_start   = -100000;
    m_up      = 1'b1;
    m_drop    = 1'b0;
  endtask

  task automatic model_step(input int c);
    bit active, sw_low;
    int cons, req, nv;
    active = (c >= m_start) && (c < m_start + DET);
    cons = 0;
    if (!active && m_pending != 0) begin
      cons    = (m_pending > 0) ? 1 : -1;
      m_start = c + 1;
      m_up    = (cons > 0);
    end
    req = int'(step_up) - int'(step_down);
    nv  = m_pending - cons + req;
    if (nv > M || nv < -M) begin
      m_pending = m_pending - cons;
      m_drop    = 1'b1;
    end else begin
      m_pending = nv;
      m_drop    = 1'b0;
    end
    sw_low = (c >= p_start) && (c < p_start + PR);
    if (press && !sw_low) p_start = c + 1;
  endtask

  function automatic logic [1:0] exp_ab(input int d);
    int e;
    e = d - m_start;
    if (e < 0 || e >= 3 * P) return 2'b11;
    if (e < P)     return m_up ? 2'b10 : 2'b01;
    if (e < 2 * P) return 2'b00;
    return m_up ? 2'b01 : 2'b10;
  endfunction

  function automatic logic exp_busy(input int d);
    return (d >= m_start) && (d < m_start + DET);
  endfunction

  function automatic logic exp_sw(input int d);
    return !((d >= p_start) && (d < p_start + PR));
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_all();
    check("ab",       {6'd0, out_a, out_b}, {6'd0, exp_ab(cyc)});
    check("busy",     {7'd0, busy},         {7'd0, exp_busy(cyc)});
    check("switch_n", {7'd0, switch_n},     {7'd0, exp_sw(cyc)});
    check("pending",  pending,              8'(m_pending));
    check("dropped",  {7'd0, dropped},      {7'd0, m_drop});
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step(cyc);
    cyc++;
    #1;
    check_all();
  endtask

  task automatic idle_ticks(input int n);
    step_up = 0; step_down = 0; press = 0;
    repeat (n) tick();
  endtask

  int lows;

  initial begin
    rst = 1'b1; step_up = 0; step_down = 0; press = 0;
    cyc = 0;
    model_reset();
    #1;
    check("rst_ab",  {6'd0, out_a, out_b}, 8'h03);
    check("rst_pnd", pending, 8'h00);
    repeat (3) tick();
    rst = 1'b0;
    idle_ticks(5);

    // Single up detent
    step_up = 1; tick(); step_up = 0;
    check("up_pend1", pending, 8'h01);
    tick();
    check("up_pend0", pending, 8'h00);
    check("up_p1",    {6'd0, out_a, out_b}, 8'h02);
    check("up_busy",  {7'd0, busy}, 8'h01);
    repeat (4) tick();
    check("up_p2",    {6'd0, out_a, out_b}, 8'h00);
    repeat (4) tick();
    check("up_p3",    {6'd0, out_a, out_b}, 8'h01);
    repeat (4) tick();
    check("up_gap",   {6'd0, out_a, out_b}, 8'h03);
    check("up_gbusy", {7'd0, busy}, 8'h01);
    repeat (8) tick();
    check("up_idle",  {7'd0, busy}, 8'h00);
    idle_ticks(3);

    // Single down detent
    step_down = 1; tick(); step_down = 0;
    check("dn_pend", pending, 8'hFF);
    tick();
    check("dn_p1", {6'd0, out_a, out_b}, 8'h01);
    repeat (8) tick();
    check("dn_p3", {6'd0, out_a, out_b}, 8'h02);
    idle_ticks(20);

    // Simultaneous up and down cancel
    step_up = 1; step_down = 1; tick(); step_up = 0; step_down = 0;
    check("both_pend", pending, 8'h00);
    check("both_drop", {7'd0, dropped}, 8'h00);
    tick();
    check("both_busy", {7'd0, busy}, 8'h00);
    idle_ticks(3);

    // Saturation burst
    step_up = 1; repeat (5) tick(); step_up = 0;
    check("sat_pend", pending, 8'h03);
    check("sat_drop", {7'd0, dropped}, 8'h01);
    idle_ticks(100);

    // Down request during P2 of an up detent
    step_up = 1; tick(); step_up = 0;
    repeat (5) tick();
    check("mid_p2", {6'd0, out_a, out_b}, 8'h00);
    step_down = 1; tick(); step_down = 0;
    check("mid_pend", pending, 8'hFF);
    repeat (16) tick();
    check("mid_next_dn", {6'd0, out_a, out_b}, 8'h01);
    check("mid_pend0",   pending, 8'h00);
    idle_ticks(30);

    // Press, re-press while low is ignored
    lows = 0;
    press = 1; tick(); lows += int'(!switch_n);
    press = 0; tick(); lows += int'(!switch_n);
    press = 1; tick(); lows += int'(!switch_n);
    press = 0;
    repeat (7) begin tick(); lows += int'(!switch_n); end
    check("press_len", 8'(lows), 8'd6);

    // Async reset mid-detent with button low
    step_up = 1; press = 1; tick(); step_up = 0; press = 0;
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    check("arst_ab",  {6'd0, out_a, out_b}, 8'h03);
    check("arst_sw",  {7'd0, switch_n}, 8'h01);
    check("arst_pnd", pending, 8'h00);
    check("arst_bsy", {7'd0, busy}, 8'h00);
    model_reset();
    repeat (2) tick();
    rst = 1'b0;
    idle_ticks(3);

    // Randomized traffic with up/down bursts to exercise saturation
    for (int i = 0; i < 3000; i++) begin
      if ((i % 500) < 60) begin
        step_up   = ((i % 1000) < 500) ? 1'($urandom_range(0, 1)) : 1'b0;
        step_down = ((i % 1000) >= 500) ? 1'($urandom_range(0, 1)) : 1'b0;
      end else begin
        step_up   = ($urandom_range(0, 15) == 0);
        step_down = ($urandom_range(0, 15) == 0);
      end
      press = ($urandom_range(0, 40) == 0);
      tick();
    end
    idle_ticks(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
